keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Input-side counterpart of the multiplexed seven-segment driver. It time-multiplexes a 4x4 matrix keypad: it drives one row low at a time, senses the active-low column lines, debounces the full 16-key snapshot, and reports key presses as a code plus a one-cycle strobe. It sits between the board pins and user logic in the board top, running on the board clock.

Parameters:
SCAN_DIV, 1024, clock cycles each row is driven before its columns are sampled; legal values are 4 or more.
DEBOUNCE, 4, consecutive identical full-scan snapshots required beyond the first before the snapshot is accepted; legal values are 1 or more.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
col_n  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk
row_n  output  4  keypad row drive, one-hot active-low
key_code  output  4  index of the reported key, equal to row*4+col; held between events
key_valid  output  1  one-cycle strobe marking a new key_code
key_down  output  1  high while the debounced key set is non-empty

Behaviour:
- Decided interface: one clock (clk); reset rst_n is synchronous, active-low.
- Reset values:
  - row_n=4'b1110 (row 0 active); div counter=0; row index=0.
  - col synchronizer=4'hF; snapshot=0; prev_snapshot=0; stable_cnt=0; stable_keys=0.
  - key_code=0; key_valid=0; key_down=0.
- Reset asserted mid-scan takes effect on the next edge and discards any partial snapshot.
- Synchronizer: col_n passes through 2 flops before use. pressed[c] = ~col_sync[c].
- Scan timing:
  - div counts 0..SCAN_DIV-1 while row r is driven (row_n = ~(1<<r)).
  - At div==SCAN_DIV-1: snapshot bits [r*4+3 : r*4] <= pressed; then r <= r+1 mod 4 and div <= 0.
  - Scan period = 4*SCAN_DIV cycles. The 2-cycle sync delay is absorbed because SCAN_DIV is 4 or more.
- End-of-scan, in the sample cycle of row 3, using the completed 16-bit snapshot S including row 3 bits:
  - If S==prev_snapshot: stable_cnt <= min(stable_cnt+1, DEBOUNCE).
  - Otherwise: stable_cnt <= 0.
  - Always: prev_snapshot <= S.
  - When stable_cnt transitions to DEBOUNCE, stable_keys <= S. Once saturated, later equal scans change nothing.
- Event generation, in the cycle after stable_keys updates (registered):
  - key_down = |stable_keys.
  - If the new stable_keys is non-zero and either the old value was zero or its lowest set index differs from the new lowest set index: key_code <= lowest set index of the new stable_keys, and key_valid=1 for exactly one cycle.
  - Release (stable_keys becomes 0): key_down drops, no strobe, key_code holds.
  - Multiple keys held: report only the lowest index. Adding a higher-index key gives no new strobe. Releasing the lowest key while others stay held gives a strobe with the new lowest index.
- Latency: a press that is clean from before a scan starts is reported DEBOUNCE+1 scan periods later, plus at most 1 scan of alignment, plus 1 cycle.
- Any bounce that yields a differing snapshot restarts the count. key_valid never pulses twice for one continuous press.
- stable_cnt width: $clog2(DEBOUNCE+1). The div counter is sized for SCAN_DIV.

Test Plan:
- Reset, then idle (col_n=4'hF) for 10 scans with SCAN_DIV=4, DEBOUNCE=2: row_n cycles 1110, 1101, 1011, 0111 with a period of 4 cycles each; key_valid, key_down and key_code remain 0.
- Hold key 5 (col_n[1] low only while row_n==4'b1101), SCAN_DIV=4, DEBOUNCE=2: exactly one key_valid with key_code=5 within 65 cycles; key_down=1 while held; after release, key_down=0 within 4 scans with no strobe.
- Key 5 bouncing (col toggled every 3 cycles for 100 cycles) then held steady: no strobe during the bounce, then exactly one strobe with key_code=5.
- Hold key 9, then add key 2: strobe with code 9, then a strobe with code 2. Release key 2: strobe with code 9. Release key 9: no strobe and key_down=0.
- Assert rst_n=0 for 1 cycle mid-debounce of key 14, then keep holding: all outputs are at reset values the cycle after; a single strobe with code 14 arrives a full debounce time after reset release.
- Corner keys 0 and 15 pressed separately: strobes with codes 0 and 15 respectively, confirming row/column index mapping.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 matrix keypad by pulling one row low at a time, samples the
// active-low column lines through a two-flop synchronizer, debounces the full
// 16-key snapshot across whole scans, and reports the lowest pressed key.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   col_n[3:0] keypad columns, active-low, asynchronous to clk
//   row_n[3:0] keypad row drive, one-hot active-low
//   key_code   index (row*4+col) of the reported key, held between events
//   key_valid  one-cycle strobe marking a new key_code
//   key_down   high while the debounced key set is non-empty
module keypad_scanner #(
    parameter int SCAN_DIV = 1024,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEBOUNCE - 1);

    logic [DIV_W-1:0] div;
    logic [1:0]       row_idx;
    logic [3:0]       col_meta;
    logic [3:0]       col_sync;
    logic [15:0]      snapshot;
    logic [15:0]      prev_snapshot;
    logic [CNT_W-1:0] stable_cnt;
    logic [15:0]      stable_keys;
    logic [15:0]      stable_keys_d;

    logic [3:0]       pressed;
    logic [15:0]      snap_full;
    logic [3:0]       new_low;
    logic [3:0]       old_low;
    logic             strobe;

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        lowest_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_idx = i[3:0];
        end
    endfunction

    assign pressed = ~col_sync;

    // Snapshot as it will look once the current row's columns are merged in;
    // on the row-3 sample this is the completed scan.
    always_comb begin
        snap_full = snapshot;
        snap_full[{row_idx, 2'b00} +: 4] = pressed;
    end

    // A strobe is due when the debounced set gains a new lowest key, either
    // from empty or because the previous lowest key was released.
    assign new_low = lowest_idx(stable_keys);
    assign old_low = lowest_idx(stable_keys_d);
    assign strobe  = (stable_keys != 16'd0) &&
                     ((stable_keys_d == 16'd0) || (new_low != old_low));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div           <= '0;
            row_idx       <= 2'd0;
            row_n         <= 4'b1110;
            col_meta      <= 4'hF;
            col_sync      <= 4'hF;
            snapshot      <= 16'd0;
            prev_snapshot <= 16'd0;
            stable_cnt    <= '0;
            stable_keys   <= 16'd0;
            stable_keys_d <= 16'd0;
            key_code      <= 4'd0;
            key_valid     <= 1'b0;
            key_down      <= 1'b0;
        end else begin
            col_meta      <= col_n;
            col_sync      <= col_meta;

            stable_keys_d <= stable_keys;
            key_valid     <= strobe;
            key_down      <= |stable_keys;
            if (strobe) key_code <= new_low;

            if (div == DIV_LAST) begin
                div      <= '0;
                row_idx  <= row_idx + 2'd1;
                row_n    <= ~(4'b0001 << (row_idx + 2'd1));
                snapshot <= snap_full;

                if (row_idx == 2'd3) begin
                    prev_snapshot <= snap_full;
                    if (snap_full == prev_snapshot) begin
                        // Saturate so a long hold never re-accepts the set.
                        if (stable_cnt != CNT_MAX) begin
                            stable_cnt <= stable_cnt + CNT_W'(1);
                            if (stable_cnt == CNT_PRE) stable_keys <= snap_full;
                        end
                    end else begin
                        stable_cnt <= '0;
                    end
                end
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Drives keypad_scanner with a behavioural 4x4 keypad and checks it against a
// scan-level model of the debounce and reporting rules.
//
// Ports: none (top-level bench).
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int SCAN_CYC = 4 * SCAN_DIV;

    logic       clk;
    logic       rst_n;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] held;
    logic        bounce_on;
    logic        bounce_lvl;
    logic [15:0] keys_now;

    int n_chk;
    int n_err;
    int strobes;
    logic [3:0] last_code;

    // scan-level reference state
    logic [15:0] m_prev;
    int          m_cnt;
    logic [15:0] m_stable;
    int          m_code;
    int          exp_strobes;
    int          exp_down;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its column to its row when driven low.
    assign keys_now = held | {10'd0, bounce_on & bounce_lvl, 5'd0};

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) col_n = col_n & ~keys_now[r*4 +: 4];
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid === 1'b1) begin
            strobes   = strobes + 1;
            last_code = key_code;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int low_idx(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_prev      = 16'd0;
        m_cnt       = 0;
        m_stable    = 16'd0;
        m_code      = 0;
        exp_strobes = 0;
        exp_down    = 0;
    endtask

    // One full scan with a constant key set, entered and left aligned to the
    // start of row 0. Checks the outcome predicted by the previous scan, then
    // advances the model with this scan's snapshot.
    task automatic run_scan(input logic [15:0] keys);
        int s0;
        int ocnt;
        logic [15:0] ns;
        logic [3:0] er;
        held = keys;
        s0 = strobes;
        for (int i = 0; i < SCAN_CYC; i++) begin
            er = 4'b0001 << (i / SCAN_DIV);
            er = ~er;
            chk("row_n", row_n, er);
            @(posedge clk);
            #1;
        end
        chk("strobe_count", strobes - s0, exp_strobes);
        if (exp_strobes == 1) chk("strobe_code", last_code, m_code);
        chk("key_code", key_code, m_code);
        chk("key_down", key_down, exp_down);

        ocnt = m_cnt;
        if (keys == m_prev) m_cnt = (m_cnt < DEBOUNCE) ? m_cnt + 1 : DEBOUNCE;
        else m_cnt = 0;
        ns = m_stable;
        if (m_cnt == DEBOUNCE && ocnt != DEBOUNCE) ns = keys;
        m_prev = keys;
        exp_strobes = 0;
        if (ns != 16'd0 && (m_stable == 16'd0 || low_idx(ns) != low_idx(m_stable))) begin
            exp_strobes = 1;
            m_code = low_idx(ns);
        end
        exp_down = (ns != 16'd0) ? 1 : 0;
        m_stable = ns;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_row_n"}, row_n, 4'b1110);
        chk({tag, "_valid"}, key_valid, 1'b0);
        chk({tag, "_down"}, key_down, 1'b0);
        chk({tag, "_code"}, key_code, 4'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int s0;
        int sel;
        int hold;
        logic [15:0] k;

        n_chk = 0;
        n_err = 0;
        strobes = 0;
        last_code = 4'd0;
        held = 16'd0;
        bounce_on = 1'b0;
        bounce_lvl = 1'b0;
        rst_n = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // idle scanning
        for (int i = 0; i < 10; i++) run_scan(16'd0);

        // first-press latency for key 5, press clean before the scan starts
        held = 16'd1 << 5;
        s0 = strobes;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (key_valid === 1'b1) break;
        end
        chk("latency", n, SCAN_CYC * (DEBOUNCE + 1) + 1);
        chk("latency_code", key_code, 4'd5);
        repeat (SCAN_CYC - (n % SCAN_CYC)) @(posedge clk);
        #1;
        chk("latency_strobes", strobes - s0, 1);
        m_prev = 16'd1 << 5;
        m_cnt = DEBOUNCE;
        m_stable = 16'd1 << 5;
        m_code = 5;
        exp_strobes = 0;
        exp_down = 1;
        for (int i = 0; i < 3; i++) run_scan(16'd1 << 5);
        for (int i = 0; i < 4; i++) run_scan(16'd0);

        // key 5 bouncing every 3 cycles, then held steady
        held = 16'd0;
        s0 = strobes;
        bounce_on = 1'b1;
        bounce_lvl = 1'b1;
        for (int i = 0; i < 6 * SCAN_CYC; i++) begin
            if (i % 3 == 0 && i != 0) bounce_lvl = ~bounce_lvl;
            @(posedge clk);
            #1;
        end
        bounce_on = 1'b0;
        chk("bounce_quiet", strobes - s0, 0);
        run_scan(16'd0);
        for (int i = 0; i < 5; i++) run_scan(16'd1 << 5);
        for (int i = 0; i < 4; i++) run_scan(16'd0);

        // multi-key: 9, add 2, release 2, release 9
        for (int i = 0; i < 4; i++) run_scan(16'd1 << 9);
        for (int i = 0; i < 4; i++) run_scan((16'd1 << 9) | (16'd1 << 2));
        for (int i = 0; i < 4; i++) run_scan(16'd1 << 9);
        for (int i = 0; i < 4; i++) run_scan(16'd0);

        // corner keys
        for (int i = 0; i < 4; i++) run_scan(16'd1 << 0);
        for (int i = 0; i < 4; i++) run_scan(16'd0);
        for (int i = 0; i < 4; i++) run_scan(16'd1 << 15);
        for (int i = 0; i < 4; i++) run_scan(16'd0);

        // reset mid-scan while key 14 is being debounced
        for (int i = 0; i < 2; i++) run_scan(16'd1 << 14);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) run_scan(16'd1 << 14);
        for (int i = 0; i < 4; i++) run_scan(16'd0);

        // randomized key sets and hold lengths
        for (int seg = 0; seg < 40; seg++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 2) k = 16'd0;
            else if (sel <= 6) k = 16'd1 << $urandom_range(0, 15);
            else if (sel <= 8) k = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            else k = 16'($urandom);
            hold = $urandom_range(1, 5);
            for (int i = 0; i < hold; i++) run_scan(k);
        end
        for (int i = 0; i < 4; i++) run_scan(16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
